// File: rtl/rv32i_alu.sv
// RV32I integer ALU: combinational result/zero/illegal_op for the execute stage,
// plus a registered copy of result and zero for trace or later pipelining.
module rv32i_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_SLT  = 4'h8,
        OP_SLTU = 4'h9
    } alu_op_e;

    logic [4:0]      shamt;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] result_d;
    logic            zero_d;

    // Only the low five bits of b select the shift distance.
    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        result     = '0;
        illegal_op = 1'b0;
        case (alu_op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            default: illegal_op = 1'b1;
        endcase
    end

    assign zero = (result == '0);

    always_comb begin
        result_d = result;
        zero_d   = zero;
        if (rst) begin
            result_d = '0;
            zero_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        result_q <= result_d;
        zero_q   <= zero_d;
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector bench for rv32i_alu: a table of combinational vectors,
// then hand-written sequences for the registered path and reset.
module tb_rv32i_alu;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;
    logic [31:0] result_q;
    logic        zero_q;

    int n_vec;
    int n_err;
    vec_t vecs[$];

    rv32i_alu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op),
        .result_q   (result_q),
        .zero_q     (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] er, input logic ez, input logic ei);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.exp_res = er; v.exp_zero = ez; v.exp_ill = ei;
        vecs.push_back(v);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        add_vec(4'h0, 32'd10,        32'd7,          32'd17,         1'b0, 1'b0);
        add_vec(4'h1, 32'd10,        32'd10,         32'd0,          1'b1, 1'b0);
        add_vec(4'h0, 32'hFFFFFFFF,  32'd1,          32'd0,          1'b1, 1'b0);
        add_vec(4'h1, 32'd0,         32'd1,          32'hFFFFFFFF,   1'b0, 1'b0);
        add_vec(4'h2, 32'hF0F00000,  32'h0FF000FF,   32'h00F00000,   1'b0, 1'b0);
        add_vec(4'h3, 32'hF0F00000,  32'h0FF000FF,   32'hFFF000FF,   1'b0, 1'b0);
        add_vec(4'h4, 32'hF0F00000,  32'h0FF000FF,   32'hFF0000FF,   1'b0, 1'b0);
        add_vec(4'h5, 32'd1,         32'd8,          32'h00000100,   1'b0, 1'b0);
        add_vec(4'h6, 32'h80000000,  32'd4,          32'h08000000,   1'b0, 1'b0);
        add_vec(4'h7, 32'h80000000,  32'd4,          32'hF8000000,   1'b0, 1'b0);
        add_vec(4'h5, 32'd1,         32'h21,         32'h00000002,   1'b0, 1'b0);
        add_vec(4'h7, 32'h80000000,  32'h24,         32'hF8000000,   1'b0, 1'b0);
        add_vec(4'h7, 32'h80000001,  32'd0,          32'h80000001,   1'b0, 1'b0);
        add_vec(4'h6, 32'h80000000,  32'd31,         32'h00000001,   1'b0, 1'b0);
        add_vec(4'h7, 32'h40000000,  32'd30,         32'h00000001,   1'b0, 1'b0);
        add_vec(4'h8, 32'hFFFFFFFF,  32'd1,          32'd1,          1'b0, 1'b0);
        add_vec(4'h8, 32'd5,         32'd5,          32'd0,          1'b1, 1'b0);
        add_vec(4'h8, 32'd1,         32'hFFFFFFFF,   32'd0,          1'b1, 1'b0);
        add_vec(4'h8, 32'h80000000,  32'h7FFFFFFF,   32'd1,          1'b0, 1'b0);
        add_vec(4'h9, 32'hFFFFFFFF,  32'd1,          32'd0,          1'b1, 1'b0);
        add_vec(4'h9, 32'd1,         32'd2,          32'd1,          1'b0, 1'b0);
        add_vec(4'h9, 32'h80000000,  32'h7FFFFFFF,   32'd0,          1'b1, 1'b0);
        add_vec(4'hA, 32'h12345678,  32'h9ABCDEF0,   32'd0,          1'b1, 1'b1);
        add_vec(4'hC, 32'hDEADBEEF,  32'h00000001,   32'd0,          1'b1, 1'b1);
        add_vec(4'hF, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'd0,          1'b1, 1'b1);

        rst = 1'b1; a = '0; b = '0; alu_op = 4'h0;
        #1;

        foreach (vecs[i]) begin
            a = vecs[i].a; b = vecs[i].b; alu_op = vecs[i].op;
            #1;
            chk($sformatf("vec%0d result", i), result, vecs[i].exp_res);
            chk($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
            chk($sformatf("vec%0d illegal_op", i), {31'd0, illegal_op}, {31'd0, vecs[i].exp_ill});
        end

        // Every undefined opcode must be illegal with a zero result, whatever the operands.
        for (int op = 10; op < 16; op++) begin
            a = $urandom; b = $urandom; alu_op = op[3:0];
            #1;
            chk($sformatf("illegal op%0h result", op), result, 32'd0);
            chk($sformatf("illegal op%0h zero", op), {31'd0, zero}, 32'd1);
            chk($sformatf("illegal op%0h flag", op), {31'd0, illegal_op}, 32'd1);
        end

        // Registered path: reset held for two edges while a nonzero result is presented.
        @(negedge clk);
        rst = 1'b1; a = 32'd10; b = 32'd7; alu_op = 4'h0;
        @(posedge clk); @(posedge clk);
        #1;
        chk("reset result_q", result_q, 32'd0);
        chk("reset zero_q", {31'd0, zero_q}, 32'd1);
        chk("reset comb result", result, 32'd17);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("pre-edge result_q", result_q, 32'd0);
        chk("pre-edge zero_q", {31'd0, zero_q}, 32'd1);
        @(posedge clk);
        #1;
        chk("add result_q", result_q, 32'd17);
        chk("add zero_q", {31'd0, zero_q}, 32'd0);

        @(negedge clk);
        a = 32'd10; b = 32'd10; alu_op = 4'h1;
        #1;
        chk("sub hold result_q", result_q, 32'd17);
        @(posedge clk);
        #1;
        chk("sub result_q", result_q, 32'd0);
        chk("sub zero_q", {31'd0, zero_q}, 32'd1);

        @(negedge clk);
        a = 32'd10; b = 32'd7; alu_op = 4'h0;
        @(posedge clk);
        #1;
        chk("re-add result_q", result_q, 32'd17);

        // Mid-stream reset clears only the registered copy.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst comb result", result, 32'd17);
        chk("rst pre-edge result_q", result_q, 32'd17);
        @(posedge clk);
        #1;
        chk("mid rst result_q", result_q, 32'd0);
        chk("mid rst zero_q", {31'd0, zero_q}, 32'd1);
        chk("mid rst comb result", result, 32'd17);
        chk("mid rst comb zero", {31'd0, zero}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post rst result_q", result_q, 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
